// File: rtl/fwd_scoreboard_if.sv
// ID <-> hazard/forwarding unit bundle.
// The master drives the ID-stage inputs; the slave returns the stall and EX selects.
interface fwd_scoreboard_if #(
   parameter int NSTAGE = 3,
   parameter int FW_W   = $clog2(NSTAGE)
);
   logic            id_valid;
   logic [4:0]      id_rs1_id;
   logic [4:0]      id_rs2_id;
   logic            id_rs1_used;
   logic            id_rs2_used;
   logic [4:0]      id_rd_id;
   logic            id_we;
   logic [FW_W-1:0] id_lat;
   logic            ex_flush;
   logic            id_stall;
   logic [FW_W-1:0] ex_fw_rs1;
   logic [FW_W-1:0] ex_fw_rs2;

   modport master (
      output id_valid, id_rs1_id, id_rs2_id, id_rs1_used, id_rs2_used,
      output id_rd_id, id_we, id_lat, ex_flush,
      input  id_stall, ex_fw_rs1, ex_fw_rs2
   );

   modport slave (
      input  id_valid, id_rs1_id, id_rs2_id, id_rs1_used, id_rs2_used,
      input  id_rd_id, id_we, id_lat, ex_flush,
      output id_stall, ex_fw_rs1, ex_fw_rs2
   );
endinterface

// File: rtl/fwd_scoreboard.sv
// Per-register scoreboard: ID stall decision and registered EX forwarding selects.
// FWD_SCOREBOARD_FORWARD_EN enables forwarding; undefined gives a pure interlock.
module fwd_scoreboard #(
   parameter int NSTAGE = 3,
   parameter int FW_W   = $clog2(NSTAGE)
) (
   input logic            clk,
   input logic            rst,
   fwd_scoreboard_if.slave sb
);
   localparam logic [FW_W-1:0] AGE_LAST = FW_W'(NSTAGE - 2);

   logic [31:0]     ent_valid;
   logic [FW_W-1:0] ent_age [32];
   logic [4:0]      src_id  [2];
   logic            src_used[2];
   logic            haz     [2];
   logic [FW_W-1:0] sel     [2];
   logic            issue;
   logic            wr_en;

   assign src_id[0]   = sb.id_rs1_id;
   assign src_id[1]   = sb.id_rs2_id;
   assign src_used[0] = sb.id_rs1_used;
   assign src_used[1] = sb.id_rs2_used;

`ifdef FWD_SCOREBOARD_FORWARD_EN
   logic [FW_W-1:0] ent_lat [32];
   logic [FW_W-1:0] k_of    [2];

   // Stage the producer occupies once the consumer reaches EX.
   assign k_of[0] = ent_age[src_id[0]] + 1'b1;
   assign k_of[1] = ent_age[src_id[1]] + 1'b1;
`else
   logic unused_lat;

   assign unused_lat = ^sb.id_lat;
`endif

   always_comb begin
      for (int s = 0; s < 2; s++) begin
         haz[s] = 1'b0;
         sel[s] = '0;
         if (src_used[s] && src_id[s] != 5'd0 &&
             ent_valid[src_id[s]]) begin
`ifdef FWD_SCOREBOARD_FORWARD_EN
            if (k_of[s] < ent_lat[src_id[s]])
               haz[s] = 1'b1;
            else
               sel[s] = k_of[s];
`else
            haz[s] = 1'b1;
`endif
         end
      end
   end

   assign sb.id_stall = !rst && sb.id_valid && !sb.ex_flush &&
                        (haz[0] || haz[1]);
   assign issue = sb.id_valid && !sb.id_stall && !sb.ex_flush;
   assign wr_en = issue && sb.id_we && sb.id_rd_id != 5'd0;

   always_ff @(posedge clk) begin
      if (rst) begin
         ent_valid    <= '0;
         sb.ex_fw_rs1 <= '0;
         sb.ex_fw_rs2 <= '0;
      end else begin
         for (int r = 1; r < 32; r++) begin
            if (wr_en && sb.id_rd_id == 5'(r)) begin
               ent_valid[r] <= 1'b1;
               ent_age[r]   <= '0;
`ifdef FWD_SCOREBOARD_FORWARD_EN
               ent_lat[r]   <= sb.id_lat;
`endif
            end else if (ent_valid[r]) begin
               // Flush kills only the producer currently in EX (age 0).
               if ((sb.ex_flush && ent_age[r] == '0) ||
                   ent_age[r] == AGE_LAST)
                  ent_valid[r] <= 1'b0;
               else
                  ent_age[r] <= ent_age[r] + 1'b1;
            end
         end
         sb.ex_fw_rs1 <= issue ? sel[0] : '0;
         sb.ex_fw_rs2 <= issue ? sel[1] : '0;
      end
   end
endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised hazard and forwarding unit for the in-order pipeline. It keeps a per-register scoreboard of in-flight writes, with an age counter and a result latency for each entry. At ID it decides whether to stall (load-use and any longer-latency producer) and which downstream stage each source operand must be forwarded from. It then hands a registered forwarding select to EX.

## Interface
- `NSTAGE`, default 3: number of pipeline stages after ID (EX=stage 0 … WB=stage NSTAGE-1); legal range 2..8.
- `FW_W`, default `$clog2(NSTAGE)`: width of the forwarding selects and latency fields. Derived; do not override.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  the ID instruction is real (not a bubble).
- `id_rs1_id`, `id_rs2_id`  in  5 each  source register indices.
- `id_rs1_used`, `id_rs2_used`  in  1 each  the operand is actually read; unused operands never stall or forward.
- `id_rd_id`  in  5  destination register.
- `id_we`  in  1  the instruction writes `id_rd_id`.
- `id_lat`  in  FW_W  stage index at whose entry the result becomes forwardable. 1 is an ALU result visible in MEM; 2 is a load visible in WB. Legal range 1..NSTAGE-1.
- `ex_flush`  in  1  kill the instructions currently in ID and EX.
- `id_stall`  out  1  combinational: hold ID and inject a bubble into EX.
- `ex_fw_rs1`, `ex_fw_rs2`  out  FW_W each  registered select for EX. 0 means use the register-file value; k≥1 means forward from stage k (1=MEM, 2=WB, …).

## Operation
- Scoreboard: one entry for each of x1..x31. Each entry holds `valid`, `age` (FW_W bits, 0 = producer in EX) and `lat` (FW_W). x0 has no entry: it never stalls and its select is always 0.
- Issue: an instruction issues when `id_valid && !id_stall && !ex_flush`. If it also has `id_we && id_rd_id != 0`, the entry for `id_rd_id` is written with valid=1, age=0, lat=`id_lat`. This overwrites any older entry for that register, so the youngest writer wins (WAW).
- Aging: every cycle, each valid entry that is not being overwritten does one of two things.
  - If age == NSTAGE-2, it is cleared (valid=0). The producer then sits in the last stage and the register file holds the value by the time the consumer reaches EX.
  - Otherwise its age increments by 1.
- Operand check (combinational, per used source s with a valid entry e):
  - Required stage k = e.age + 1. This is where the producer will be when the consumer is in EX.
  - Hazard if k < e.lat. Otherwise the select is k.
  - With no entry, an unused operand, or register 0, the select is 0 and there is no hazard.
- `id_stall` = `id_valid && !ex_flush && (hazard_rs1 || hazard_rs2)`.
- The same-cycle read of an entry being written by this issue sees the pre-issue state (read-before-write).
- Flush: `ex_flush` clears every entry with age == 0 at that edge, i.e. the killed EX instruction. It suppresses issue and forces the next EX selects to 0. Older entries age normally.

## Timing
- `id_stall` is combinational from the ID inputs and the scoreboard state, with zero-cycle latency.
- `ex_fw_rs1`/`ex_fw_rs2` register the ID-stage selects at each edge, giving one cycle of latency.
  - They load 0 when the ID instruction does not issue (stall, flush, or `!id_valid`), so a bubble carries no forwarding.
- Reset: all entries are invalid, `ex_fw_rs1` = `ex_fw_rs2` = 0, and `id_stall` = 0 while `rst` is high.
  - Reset asserted mid-operation discards all pending producers at that edge; nothing is retained.
- Load-use with NSTAGE=3 and lat=2 gives exactly one stall cycle, after which the select is 2 (WB).
- An ALU producer (lat=1) followed back-to-back by its consumer gives no stall and a select of 1.

## Configuration
- `FWD_SCOREBOARD_FORWARD_EN` defined: forwarding behaves as described above.
- Macro undefined: pure interlock.
  - Any used source with a valid entry stalls until that entry clears.
  - `ex_fw_rs1`/`ex_fw_rs2` are constant 0.
  - Scoreboard aging and flush behaviour are unchanged.

## Test plan
All cases use NSTAGE=3.
- ALU chain: issue `add x5` (lat=1), then the next cycle a consumer reading x5 on rs1 → `id_stall`=0 and `ex_fw_rs1`=1 one cycle later. With the macro undefined: stall for 2 cycles, then select 0.
- Load-use: issue `lw x6` (lat=2), then a consumer reading x6 on both rs1 and rs2 → `id_stall`=1 for 1 cycle, then `ex_fw_rs1`=`ex_fw_rs2`=2.
- Distance: producer of x8 (lat=1), two unrelated instructions, then a consumer of x8 → select 0 and no stall. At distance 1 the select is 2.
- WAW: `lw x7` (lat=2) then `add x7` (lat=1), then a consumer of x7 → no stall and select 1 (youngest wins).
- x0 and unused: write x0 with lat=2, then read x0 → no stall and select 0. Read x9 with `id_rs2_used`=0 while x9 is pending → no stall and select 0.
- Flush and reset:
  - `ex_flush` in the cycle a `lw x10` sits in EX, then a consumer of x10 → no stall and select 0.
  - `rst` pulsed while a load is pending → all entries cleared; the next consumer gets no stall and select 0.
